updown_counter_mod: RTL and testbench

//  Parametrised up/down step counter with programmable modulus, step size,

---
 rtl/updown_counter_mod.sv | 136 +++++++++++++
 tb/tb_updown_counter_mod.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down step counter with programmable
// modulus (MAX_VAL+1), step size, wrap-or-saturate bound handling, parallel
// load, and overflow pulse / sticky reporting.
//
// Build option: define CNT_SYNC_EDGE_EN when `step` comes straight from a
// raw button. It is then synchronised and edge-detected, giving exactly one
// event per low->high transition. Without the macro, `step` is a synchronous
// per-cycle enable.
module updown_counter_mod #(
    parameter int              WIDTH    = 16,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP     = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic             uhdl,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             ovf_sticky
);

    // Illegal configurations stop elaboration rather than building a counter
    // that silently misbehaves.
    if (WIDTH < 2 || WIDTH > 32 || STEP < 1 || STEP > MAX_VAL ||
        MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_param
        $fatal(1, "updown_counter_mod: illegal WIDTH/MAX_VAL/STEP combination");
    end

    // Arithmetic is done one bit wider than the count so that neither the
    // up-sum nor the modulus loses its carry.
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MAX_VAL + 64'd1);

    // Up step. The result is {crossed_bound, next_count}.
    function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] c);
        logic [WIDTH:0] sum;
        sum = {1'b0, c} + STEP_X;
        if (sum <= MAX_X)
            step_up = {1'b0, WIDTH'(sum)};
        else if (SATURATE)
            step_up = {1'b1, MAX_C};
        else
            step_up = {1'b1, WIDTH'(sum - MOD_X)};
    endfunction

    // Down step. The result is {crossed_bound, next_count}.
    function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] c);
        logic [WIDTH:0] cx;
        cx = {1'b0, c};
        if (cx >= STEP_X)
            step_down = {1'b0, WIDTH'(cx - STEP_X)};
        else if (SATURATE)
            step_down = {1'b1, {WIDTH{1'b0}}};
        else
            step_down = {1'b1, WIDTH'(cx + MOD_X - STEP_X)};
    endfunction

    logic step_evt;

`ifdef CNT_SYNC_EDGE_EN
    // sync_q[0..1] form the metastability synchroniser, and sync_q[2] is the
    // delayed copy used to detect the rising edge.
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the raw button sample through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[1:0], step};
    end

    // Synchroniser and edge-detect flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sync_q <= 3'b000;
        else
            sync_q <= sync_d;
    end

    assign step_evt = sync_q[1] & ~sync_q[2];
`else
    assign step_evt = step;
`endif

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;

    // Next-state selection: clr beats load, and load beats a step event.
    // Lower-priority requests in the same cycle are dropped.
    always_comb begin
        count_d  = count_q;
        ovf_d    = 1'b0;
        sticky_d = sticky_q;
        if (clr) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (load) begin
            count_d = ({1'b0, load_val} > MAX_X) ? MAX_C : load_val;
        end else if (step_evt) begin
            if (uhdl)
                {ovf_d, count_d} = step_up(count_q);
            else
                {ovf_d, count_d} = step_down(count_q);
            sticky_d = sticky_q | ovf_d;
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign count      = count_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;
    assign at_max     = (count_q == MAX_C);
    assign at_min     = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod.
// Two instances run side by side:
//   a: WIDTH=4, MAX_VAL=9,   STEP=1, wrap
//   b: WIDTH=8, MAX_VAL=255, STEP=3, saturate
// A cycle-level reference model, computed from the counting rules with plain
// integer arithmetic, is compared against every output on every cycle.
// Directed constant checks cover the named scenarios.
module tb_updown_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       clr = 1'b0, load = 1'b0, step = 1'b0, uhdl = 1'b0;
    logic [3:0] load_val_a = '0;
    logic [7:0] load_val_b = '0;

    logic [3:0] count_a;
    logic [7:0] count_b;
    logic       at_max_a, at_min_a, ovf_a, sticky_a;
    logic       at_max_b, at_min_b, ovf_b, sticky_b;

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val_a),
        .step(step), .uhdl(uhdl), .count(count_a), .at_max(at_max_a),
        .at_min(at_min_a), .ovf(ovf_a), .ovf_sticky(sticky_a)
    );

    updown_counter_mod #(.WIDTH(8), .MAX_VAL(255), .STEP(3), .SATURATE(1'b1)) u_b (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val_b),
        .step(step), .uhdl(uhdl), .count(count_b), .at_max(at_max_b),
        .at_min(at_min_b), .ovf(ovf_b), .ovf_sticky(sticky_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] c;
        logic        o;
        logic        s;
    } mstate_t;

    mstate_t    ma, mb;
    logic [2:0] hist;   // step samples from the previous three edges
    bit         chk_en = 1'b0;

    function automatic logic cur_ev();
`ifdef CNT_SYNC_EDGE_EN
        return hist[1] & ~hist[2];
`else
        return step;
`endif
    endfunction

    function automatic mstate_t ref_next(input mstate_t cur, input longint mx, input longint st,
                                         input bit sat, input bit clr_i, input bit ld_i,
                                         input bit ev, input bit up, input longint lv);
        mstate_t nxt;
        longint  c;
        c     = longint'(cur.c);
        nxt.o = 1'b0;
        nxt.s = cur.s;
        if (clr_i) begin
            c     = 0;
            nxt.s = 1'b0;
        end else if (ld_i) begin
            c = (lv > mx) ? mx : lv;
        end else if (ev) begin
            if (up) begin
                if (c + st > mx) begin
                    nxt.o = 1'b1;
                    c     = sat ? mx : c + st - (mx + 1);
                end else begin
                    c = c + st;
                end
            end else begin
                if (c < st) begin
                    nxt.o = 1'b1;
                    c     = sat ? 0 : c + (mx + 1) - st;
                end else begin
                    c = c - st;
                end
            end
        end
        nxt.s = nxt.s | nxt.o;
        nxt.c = c[31:0];
        return nxt;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma   <= '0;
            mb   <= '0;
            hist <= '0;
        end else begin
            hist <= {hist[1:0], step};
            ma   <= ref_next(ma, 9, 1, 1'b0, clr, load, cur_ev(), uhdl, longint'(load_val_a));
            mb   <= ref_next(mb, 255, 3, 1'b1, clr, load, cur_ev(), uhdl, longint'(load_val_b));
        end
    end

    // Compare every output with the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_val("model_count_a", count_a, ma.c);
            check_val("model_ovf_a", ovf_a, ma.o);
            check_val("model_sticky_a", sticky_a, ma.s);
            check_val("model_at_max_a", at_max_a, ma.c == 9);
            check_val("model_at_min_a", at_min_a, ma.c == 0);
            check_val("model_count_b", count_b, mb.c);
            check_val("model_ovf_b", ovf_b, mb.o);
            check_val("model_sticky_b", sticky_b, mb.s);
            check_val("model_at_max_b", at_max_b, mb.c == 255);
            check_val("model_at_min_b", at_min_b, mb.c == 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    // One step request. The task returns on the falling edge right after the
    // edge at which the count reacts.
    task automatic do_event(input logic up);
        uhdl = up;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
`ifdef CNT_SYNC_EDGE_EN
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    logic [7:0] exp_b3 [3];
    logic       exp_o3 [3];

    initial begin
        exp_b3 = '{8'd253, 8'd255, 8'd255};
        exp_o3 = '{1'b0, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check_val("rst_count_a", count_a, 0);
        check_val("rst_at_min_a", at_min_a, 1);
        check_val("rst_sticky_a", sticky_a, 0);

        // Wrap upward through the modulus 10.
        for (int i = 0; i < 10; i++) begin
            do_event(1'b1);
            check_val("t1_count", count_a, (i + 1) % 10);
            check_val("t1_ovf", ovf_a, i == 9);
            check_val("t1_sticky", sticky_a, i == 9);
        end

        // Wrap downward from 0.
        pulse_clr();
        check_val("t2_clr_sticky", sticky_a, 0);
        do_event(1'b0);
        check_val("t2_count", count_a, 9);
        check_val("t2_ovf", ovf_a, 1);
        check_val("t2_at_max", at_max_a, 1);

        // Saturating counter with STEP=3.
        load = 1'b1; load_val_b = 8'd250; load_val_a = 4'd3;
        @(negedge clk);
        load = 1'b0;
        check_val("t3_load_b", count_b, 250);
        for (int i = 0; i < 3; i++) begin
            do_event(1'b1);
            check_val("t3_up_count", count_b, exp_b3[i]);
            check_val("t3_up_ovf", ovf_b, exp_o3[i]);
        end
        load = 1'b1; load_val_b = 8'd2;
        @(negedge clk);
        load = 1'b0;
        do_event(1'b0);
        check_val("t3_dn_count", count_b, 0);
        check_val("t3_dn_ovf", ovf_b, 1);
        do_event(1'b0);
        check_val("t3_dn2_count", count_b, 0);
        check_val("t3_dn2_ovf", ovf_b, 1);
        check_val("t3_at_min", at_min_b, 1);

        // An out-of-range load clamps to MAX_VAL and leaves sticky alone.
        load = 1'b1; load_val_a = 4'd12;
        @(negedge clk);
        load = 1'b0;
        check_val("t4_load_clamp", count_a, 9);
        check_val("t4_load_ovf", ovf_a, 0);
        check_val("t4_load_sticky", sticky_a, 1);
        // clr wins over load and step in the same cycle.
        clr = 1'b1; load = 1'b1; step = 1'b1;
        @(negedge clk);
        clr = 1'b0; load = 1'b0; step = 1'b0;
        check_val("t4_clr_count", count_a, 0);
        check_val("t4_clr_sticky", sticky_a, 0);
        check_val("t4_clr_count_b", count_b, 0);
        repeat (4) @(negedge clk);

        // Asynchronous reset between edges.
        load = 1'b1; load_val_a = 4'd9;
        @(negedge clk);
        load = 1'b0;
        do_event(1'b1);
        for (int i = 0; i < 7; i++) do_event(1'b1);
        check_val("t5_pre_count", count_a, 7);
        check_val("t5_pre_sticky", sticky_a, 1);
        #2 reset = 1'b1;
        #1;
        check_val("t5_rst_count", count_a, 0);
        check_val("t5_rst_ovf", ovf_a, 0);
        check_val("t5_rst_sticky", sticky_a, 0);
        check_val("t5_rst_at_min", at_min_a, 1);
        @(negedge clk);
        reset = 1'b0;
        do_event(1'b1);
        check_val("t5_after_count", count_a, 1);

`ifdef CNT_SYNC_EDGE_EN
        // Holding step high gives a single increment, on the third edge.
        pulse_clr();
        uhdl = 1'b1;
        step = 1'b1;
        @(negedge clk);
        check_val("t6_e1", count_a, 0);
        @(negedge clk);
        check_val("t6_e2", count_a, 0);
        @(negedge clk);
        check_val("t6_e3", count_a, 1);
        repeat (17) @(negedge clk);
        step = 1'b0;
        check_val("t6_held", count_a, 1);
        // Five separate presses give five increments.
        for (int k = 0; k < 5; k++) begin
            step = 1'b1;
            repeat (4) @(negedge clk);
            step = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check_val("t6_toggle", count_a, 6);
`endif

        // Randomised traffic, checked only against the model.
        for (int i = 0; i < 400; i++) begin
            clr        = ($urandom % 16) == 0;
            load       = ($urandom % 8) == 0;
            step       = $urandom % 2;
            uhdl       = $urandom % 2;
            load_val_a = 4'($urandom);
            load_val_b = 8'($urandom);
            @(negedge clk);
        end
        clr = 1'b0; load = 1'b0; step = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
